seq_gen_fsm: RTL and testbench

SEQ_GEN_FSM -- requirements
Module: seq_gen_fsm

---
 rtl/seq_gen_pkg.sv | 26 ++
 rtl/seq_regfile.sv | 36 +++
 rtl/seq_gen_fsm.sv | 157 +++++++++++++++
 tb/tb_seq_gen_fsm.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared definitions for the sequence generator: FSM states, mode encodings
// and the run-length clipping rule.
package seq_gen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD0 = 3'd1,
      ST_LOAD1 = 3'd2,
      ST_CALC  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic MODE_FIB   = 1'b0;
   localparam logic MODE_ARITH = 1'b1;

   // A run always writes at least the two seed terms and never past the file.
   function automatic int eff_terms(input int num_terms, input int depth);
      if (num_terms < 2)
         return 2;
      else if (num_terms > depth)
         return depth;
      else
         return num_terms;
   endfunction

endpackage

// File: rtl/seq_regfile.sv
// DEPTH x WIDTH register file: one synchronous write port, three combinational
// read ports, asynchronous active-high clear.
module seq_regfile #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr_a,
   input  logic [AW-1:0]    i_raddr_b,
   input  logic [AW-1:0]    i_raddr_c,
   output logic [WIDTH-1:0] o_rdata_a,
   output logic [WIDTH-1:0] o_rdata_b,
   output logic [WIDTH-1:0] o_rdata_c
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < DEPTH; k++)
            r_mem[k] <= '0;
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_mem[i_raddr_a];
   assign o_rdata_b = r_mem[i_raddr_b];
   assign o_rdata_c = r_mem[i_raddr_c];

endmodule

// File: rtl/seq_gen_fsm.sv
// Fibonacci / arithmetic-progression sequence generator. One term is written
// into the register file per cycle; Start/valid handshakes are single-cycle.
module seq_gen_fsm
   import seq_gen_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic             Mode,
   input  logic [WIDTH-1:0] Seed0,
   input  logic [WIDTH-1:0] Seed1,
   input  logic [AW:0]      NumTerms,
   input  logic [AW-1:0]    RdAddr,
   output logic [WIDTH-1:0] RdData,
   output logic [WIDTH-1:0] TermOut,
   output logic             TermValid,
   output logic             Busy,
   output logic             Done,
   output logic             Overflow,
   output state_t           o_dbg_state
);

   state_t           r_state;
   state_t           w_next;
   logic             r_mode;
   logic [WIDTH-1:0] r_seed0;
   logic [WIDTH-1:0] r_seed1;
   logic [AW:0]      r_n;
   logic [AW-1:0]    r_idx;
   logic             r_ovf;

   logic             w_we;
   logic [AW-1:0]    w_waddr;
   logic [WIDTH-1:0] w_wdata;
   logic [WIDTH-1:0] w_op_a;
   logic [WIDTH-1:0] w_op_b;
   logic             w_add_en;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_rd_a;
   logic [WIDTH-1:0] w_rd_b;
   logic             w_last;

   seq_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_regfile (
      .i_clk     (Clk),
      .i_rst     (Rst),
      .i_we      (w_we),
      .i_waddr   (w_waddr),
      .i_wdata   (w_wdata),
      .i_raddr_a (r_idx - AW'(1)),
      .i_raddr_b (r_idx - AW'(2)),
      .i_raddr_c (RdAddr),
      .o_rdata_a (w_rd_a),
      .o_rdata_b (w_rd_b),
      .o_rdata_c (RdData)
   );

   // Adder operands: LOAD1 forms Seed0+step, CALC forms reg[i-1]+(reg[i-2] or step).
   always_comb begin
      w_op_a   = '0;
      w_op_b   = '0;
      w_add_en = 1'b0;
      case (r_state)
         ST_LOAD1: begin
            w_op_a   = r_seed0;
            w_op_b   = r_seed1;
            w_add_en = (r_mode == MODE_ARITH);
         end
         ST_CALC: begin
            w_op_a   = w_rd_a;
            w_op_b   = (r_mode == MODE_ARITH) ? r_seed1 : w_rd_b;
            w_add_en = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_sum  = {1'b0, w_op_a} + {1'b0, w_op_b};
   assign w_last = ({1'b0, r_idx} == (r_n - (AW+1)'(1)));

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_we    = 1'b0;
      w_waddr = '0;
      w_wdata = '0;
      case (r_state)
         ST_IDLE: begin
            if (Start)
               w_next = ST_LOAD0;
         end
         ST_LOAD0: begin
            w_we    = 1'b1;
            w_wdata = r_seed0;
            w_next  = ST_LOAD1;
         end
         ST_LOAD1: begin
            w_we    = 1'b1;
            w_waddr = AW'(1);
            w_wdata = w_add_en ? w_sum[WIDTH-1:0] : r_seed1;
            w_next  = (r_n > (AW+1)'(2)) ? ST_CALC : ST_DONE;
         end
         ST_CALC: begin
            w_we    = 1'b1;
            w_waddr = r_idx;
            w_wdata = w_sum[WIDTH-1:0];
            w_next  = w_last ? ST_DONE : ST_CALC;
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Run parameters are captured only when a Start is accepted.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_mode  <= 1'b0;
         r_seed0 <= '0;
         r_seed1 <= '0;
         r_n     <= '0;
         r_idx   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (r_state == ST_IDLE && Start) begin
            r_mode  <= Mode;
            r_seed0 <= Seed0;
            r_seed1 <= Seed1;
            r_n     <= (AW+1)'(eff_terms(int'(NumTerms), DEPTH));
            r_idx   <= '0;
            r_ovf   <= 1'b0;
         end else if (w_we && w_add_en && w_sum[WIDTH]) begin
            r_ovf <= 1'b1;
         end
         if (r_state == ST_LOAD1)
            r_idx <= AW'(2);
         else if (r_state == ST_CALC)
            r_idx <= r_idx + AW'(1);
      end
   end

   assign TermValid   = w_we;
   assign TermOut     = w_wdata;
   assign Busy        = (r_state != ST_IDLE);
   assign Done        = (r_state == ST_DONE);
   assign Overflow    = r_ovf;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_gen_fsm.sv
// Bench for seq_gen_fsm: table of runs with a term scoreboard, plus hand-written
// sequences for Start-while-busy and reset during CALC.
module tb_seq_gen_fsm;
   import seq_gen_pkg::*;

   localparam int WIDTH = 16;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic             Clk;
   logic             Rst;
   logic             Start;
   logic             Mode;
   logic [WIDTH-1:0] Seed0;
   logic [WIDTH-1:0] Seed1;
   logic [AW:0]      NumTerms;
   logic [AW-1:0]    RdAddr;
   logic [WIDTH-1:0] RdData;
   logic [WIDTH-1:0] TermOut;
   logic             TermValid;
   logic             Busy;
   logic             Done;
   logic             Overflow;
   state_t           dbg_state;

   seq_gen_fsm #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .Start       (Start),
      .Mode        (Mode),
      .Seed0       (Seed0),
      .Seed1       (Seed1),
      .NumTerms    (NumTerms),
      .RdAddr      (RdAddr),
      .RdData      (RdData),
      .TermOut     (TermOut),
      .TermValid   (TermValid),
      .Busy        (Busy),
      .Done        (Done),
      .Overflow    (Overflow),
      .o_dbg_state (dbg_state)
   );

   typedef struct {
      logic        mode;
      logic [15:0] s0;
      logic [15:0] s1;
      logic [4:0]  nt;
      int          exp_n;
      logic        exp_ovf;
      logic [15:0] exp_last;
      bit          chk_last;
   } vec_t;

   vec_t             vecs[$];
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] model_reg[DEPTH];
   int               n_vec;
   int               n_fail;
   int               tv_count;

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: every written term must match the next expected term
   always @(negedge Clk) begin
      if (TermValid) begin
         tv_count++;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL term_unexpected: got %0h expected none", TermOut);
         end else begin
            chk("term_out", TermOut, exp_q.pop_front());
         end
      end else begin
         chk("term_out_idle", TermOut, 0);
      end
   end

   task automatic check_regs(input string name);
      for (int a = 0; a < DEPTH; a++) begin
         RdAddr = AW'(a);
         #1;
         chk(name, RdData, model_reg[a]);
      end
   endtask

   task automatic run_one(input logic mode, input logic [15:0] s0, input logic [15:0] s1,
                          input logic [4:0] nt, input int exp_n, input logic exp_ovf,
                          input logic [15:0] exp_last, input bit chk_last, input bit poke);
      logic [15:0] t[DEPTH];
      logic [16:0] s;
      int          n;
      int          cnt;
      bit          got_done;
      n = (nt < 2) ? 2 : ((nt > DEPTH) ? DEPTH : int'(nt));
      t[0] = s0;
      if (mode) begin
         s = {1'b0, s0} + {1'b0, s1};
         t[1] = s[15:0];
      end else begin
         t[1] = s1;
      end
      for (int i = 2; i < n; i++) begin
         s = {1'b0, t[i-1]} + {1'b0, (mode ? s1 : t[i-2])};
         t[i] = s[15:0];
      end
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(t[i]);
         model_reg[i] = t[i];
      end
      tv_count = 0;
      @(negedge Clk);
      Mode = mode; Seed0 = s0; Seed1 = s1; NumTerms = nt; Start = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
      chk("busy_running", Busy, 1);
      cnt = 0;
      got_done = 0;
      while (!got_done && cnt < 40) begin
         @(posedge Clk);
         cnt++;
         @(negedge Clk);
         if (Done) begin
            got_done = 1;
         end else if (poke && cnt >= 3) begin
            Start = 1'b1; Mode = ~mode; Seed0 = 16'hAAAA; Seed1 = 16'h5555; NumTerms = 5'd3;
         end
      end
      Start = 1'b0;
      if (!got_done) begin
         n_vec++;
         n_fail++;
         $display("FAIL done_timeout: got no Done expected edge %0d", exp_n);
      end
      chk("done_edge", cnt, exp_n);
      chk("overflow", Overflow, exp_ovf);
      chk("valid_cycles", tv_count, n);
      chk("queue_drained", exp_q.size(), 0);
      @(negedge Clk);
      chk("done_single", Done, 0);
      chk("idle_after_done", Busy, 0);
      chk("overflow_held", Overflow, exp_ovf);
      if (chk_last) begin
         RdAddr = AW'(exp_n - 1);
         #1;
         chk("last_term", RdData, exp_last);
      end
      check_regs("reg_contents");
      if (poke) begin
         for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            chk("no_restart", Busy, 0);
         end
      end
   endtask

   initial begin
      int ndone;
      n_vec = 0; n_fail = 0; tv_count = 0;
      Rst = 1'b0; Start = 1'b0; Mode = 1'b0; Seed0 = '0; Seed1 = '0; NumTerms = '0; RdAddr = '0;
      for (int i = 0; i < DEPTH; i++) model_reg[i] = '0;
      #1 Rst = 1'b1;
      #1;
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_valid", TermValid, 0);
      chk("rst_termout", TermOut, 0);
      chk("rst_ovf", Overflow, 0);
      check_regs("rst_regs");
      @(negedge Clk);
      Rst = 1'b0;

      vecs.push_back('{1'b0, 16'h0000, 16'h0001, 5'd10, 10, 1'b0, 16'd34,   1'b1});
      vecs.push_back('{1'b1, 16'h0005, 16'h0003, 5'd4,  4,  1'b0, 16'd14,   1'b1});
      vecs.push_back('{1'b0, 16'h0000, 16'h0001, 5'd31, 16, 1'b0, 16'd610,  1'b1});
      vecs.push_back('{1'b0, 16'h0007, 16'h0009, 5'd0,  2,  1'b0, 16'd9,    1'b1});
      vecs.push_back('{1'b0, 16'hFFFF, 16'h0001, 5'd3,  3,  1'b1, 16'h0000, 1'b1});
      vecs.push_back('{1'b0, 16'h0001, 16'h0001, 5'd5,  5,  1'b0, 16'd5,    1'b1});
      vecs.push_back('{1'b1, 16'hFFF0, 16'h0010, 5'd4,  4,  1'b1, 16'h0020, 1'b1});
      vecs.push_back('{1'b0, 16'h0002, 16'h0003, 5'd1,  2,  1'b0, 16'd3,    1'b1});
      vecs.push_back('{1'b1, 16'h0000, 16'h0100, 5'd16, 16, 1'b0, 16'h0F00, 1'b1});
      vecs.push_back('{1'b0, 16'h8000, 16'h8000, 5'd3,  3,  1'b1, 16'h0000, 1'b1});

      foreach (vecs[v])
         run_one(vecs[v].mode, vecs[v].s0, vecs[v].s1, vecs[v].nt, vecs[v].exp_n,
                 vecs[v].exp_ovf, vecs[v].exp_last, vecs[v].chk_last, 1'b0);

      // Start held while busy must not disturb the run in progress
      run_one(1'b0, 16'h0000, 16'h0001, 5'd10, 10, 1'b0, 16'd34, 1'b1, 1'b1);

      // reset during CALC aborts the run and clears everything
      exp_q.push_back(16'h0003);
      exp_q.push_back(16'h0004);
      exp_q.push_back(16'h0007);
      exp_q.push_back(16'h000B);
      exp_q.push_back(16'h0012);
      @(negedge Clk);
      Mode = 1'b0; Seed0 = 16'h0003; Seed1 = 16'h0004; NumTerms = 5'd12; Start = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Start = 1'b0;
      repeat (4) @(negedge Clk);
      chk("pre_rst_state", dbg_state, ST_CALC);
      #2 Rst = 1'b1;
      #1;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) model_reg[i] = '0;
      chk("midrst_busy", Busy, 0);
      chk("midrst_done", Done, 0);
      chk("midrst_valid", TermValid, 0);
      chk("midrst_ovf", Overflow, 0);
      check_regs("midrst_regs");
      @(negedge Clk);
      Rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge Clk);
         if (Done || Busy) ndone++;
      end
      chk("no_done_after_rst", ndone, 0);
      run_one(1'b0, 16'h0000, 16'h0001, 5'd10, 10, 1'b0, 16'd34, 1'b1, 1'b0);

      // random runs against the bench model
      for (int r = 0; r < 4; r++) begin
         logic        rm;
         logic [15:0] r0;
         logic [15:0] r1;
         logic [4:0]  rn;
         logic [15:0] ft[DEPTH];
         logic [16:0] fs;
         logic        fo;
         int          en;
         rm = 1'($urandom_range(0, 1));
         r0 = 16'($urandom_range(0, 65535));
         r1 = 16'($urandom_range(0, 65535));
         rn = 5'($urandom_range(0, 31));
         en = (rn < 2) ? 2 : ((rn > DEPTH) ? DEPTH : int'(rn));
         fo = 1'b0;
         ft[0] = r0;
         fs = {1'b0, r0} + {1'b0, r1};
         ft[1] = rm ? fs[15:0] : r1;
         if (rm) fo = fs[16];
         for (int i = 2; i < en; i++) begin
            fs = {1'b0, ft[i-1]} + {1'b0, (rm ? r1 : ft[i-2])};
            ft[i] = fs[15:0];
            fo = fo | fs[16];
         end
         run_one(rm, r0, r1, rn, en, fo, ft[en-1], 1'b1, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
